iob_cache_line_fill: RTL
========================

Name: iob_cache_line_fill

Overview:
- Write-side front end of the cache data memory. Drives the byte-enable RAM port (en, per-byte we, word address, data).
- Sources two kinds of write:
  - whole-line refill bursts from the back-end, one word per accepted beat;
  - single front-end byte-strobed write hits.
- Arbitrates between them, sequences refill addresses, and registers all RAM control.

Parameters:
- DATA_W, 32, RAM word width in bits; multiple of 8.
- ADDR_W, 10, RAM word address width.
- LINE_OFF_W, 2, log2(words per line); must be ≥1 and <ADDR_W.

Ports:
- clk_i  in  1  clock; all logic on rising edge.
- arst_n_i  in  1  asynchronous active-low reset.
- fill_req_i  in  1  start line refill; sampled only in IDLE.
- fill_line_i  in  ADDR_W-LINE_OFF_W  line index to refill; captured with fill_req_i.
- fill_busy_o  out  1  high while state != IDLE.
- fill_done_o  out  1  one-cycle pulse after the last refill word is written.
- be_valid_i  in  1  back-end read beat valid.
- be_data_i  in  DATA_W  back-end read beat data.
- be_ready_o  out  1  beat accepted when be_valid_i & be_ready_o.
- wr_valid_i  in  1  front-end write request.
- wr_addr_i  in  ADDR_W  front-end write word address.
- wr_strb_i  in  DATA_W/8  front-end byte strobes.
- wr_data_i  in  DATA_W  front-end write data.
- wr_ready_o  out  1  write accepted when wr_valid_i & wr_ready_o.
- ram_en_o  out  1  RAM enable.
- ram_we_o  out  DATA_W/8  RAM per-byte write enables.
- ram_addr_o  out  ADDR_W  RAM word address.
- ram_data_o  out  DATA_W  RAM write data.

Behaviour:
- Reset: clock clk_i; reset asynchronous, active-low on arst_n_i. Asserting arst_n_i low immediately forces:
  - state=IDLE, word counter=0, captured line=0;
  - fill_done_o=0;
  - ram_en_o=0, ram_we_o=0, ram_addr_o=0, ram_data_o=0.
- Combinational outputs:
  - fill_busy_o, be_ready_o, wr_ready_o are combinational from state and fill_req_i; all are 0 during reset.
  - fill_busy_o=1 in FILL and DONE.
- State machine: IDLE, FILL, DONE.
- IDLE:
  - fill_req_i=1: capture fill_line_i, counter←0, go to FILL. The RAM is idle in the next cycle.
  - else wr_valid_i=1: accept the write. Next cycle: ram_en_o=1, ram_we_o=wr_strb_i, ram_addr_o=wr_addr_i, ram_data_o=wr_data_i.
  - wr_ready_o = ~fill_req_i, i.e. refill has priority in the same cycle.
  - A write with wr_strb_i=0 is still accepted and produces a RAM cycle with en=1, we=0.
- FILL:
  - be_ready_o=1, wr_ready_o=0; front-end writes stall.
  - On each accepted beat, next cycle: ram_en_o=1, ram_we_o=all ones, ram_addr_o={line,counter}, ram_data_o=be_data_i; counter increments.
  - Beat accepted with counter=2^LINE_OFF_W-1: counter wraps to 0, go to DONE.
  - be_valid_i=0: no RAM cycle; counter holds; no timeout.
  - fill_req_i is ignored.
- DONE:
  - fill_done_o=1 for exactly this cycle, coinciding with the RAM write of the last word.
  - be_ready_o=0, wr_ready_o=0; unconditionally return to IDLE.
- RAM control:
  - Registered, 1-cycle latency from acceptance; at most one RAM write per cycle.
  - In cycles with no accepted transaction: ram_en_o=0, ram_we_o=0; ram_addr_o and ram_data_o hold their last values.
- Back-to-back acceptance:
  - Consecutive beats produce consecutive RAM writes with no bubble.
  - A line of N words, with beats every cycle, completes N+2 cycles after fill_req_i: 1 cycle to enter FILL, then N beats, then DONE.
- Reset mid-fill: abort to IDLE. Words already written stay in the RAM. No fill_done_o pulse is generated; the line's valid handling belongs to the caller.
- Address arithmetic: ram_addr_o = fill line concatenated with the LINE_OFF_W-bit counter. There is never a carry into the line field.

Test Plan:
- Reset: hold arst_n_i=0 mid-FILL with counter=2 → all outputs 0 at once. After release, state is IDLE, fill_busy_o=0, wr_ready_o=1.
- Full refill (defaults), fill_line_i=0x05, beats 0xA0..0xA3 on consecutive cycles → RAM writes to addresses 0x014..0x017, data 0xA0..0xA3, we=4'hF, in consecutive cycles. fill_done_o pulses in the cycle of the 0x017 write; fill_busy_o falls the next cycle.
- Gapped beats: be_valid_i toggles 1,0,0,1,1,0,1 → exactly 4 RAM writes at increasing addresses, none in gap cycles, single fill_done_o.
- Front-end write in IDLE: wr_addr_i=0x3FF, wr_strb_i=4'b0101, wr_data_i=0xDEADBEEF → next cycle ram_en_o=1, ram_we_o=4'b0101, ram_addr_o=0x3FF, ram_data_o=0xDEADBEEF.
- Simultaneous fill_req_i and wr_valid_i in IDLE → wr_ready_o=0 and the refill starts. A write held valid through the refill is accepted in the first IDLE cycle after DONE.
- Ignored/stalled requests during FILL: fill_req_i with fill_line_i=0x0A → ignored, addresses continue on the original line. wr_valid_i during FILL → wr_ready_o=0, no RAM write from the front end.

Source files
------------

// File: rtl/iob_cache_line_fill.sv
// Write-side front end of the cache data memory: arbitrates line refills against
// front-end write hits and drives a registered byte-enable RAM write port.
module iob_cache_line_fill #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 10,
    parameter int LINE_OFF_W = 2
) (
    input  logic                         clk_i,
    input  logic                         arst_n_i,
    input  logic                         fill_req_i,
    input  logic [ADDR_W-LINE_OFF_W-1:0] fill_line_i,
    output logic                         fill_busy_o,
    output logic                         fill_done_o,
    input  logic                         be_valid_i,
    input  logic [DATA_W-1:0]            be_data_i,
    output logic                         be_ready_o,
    input  logic                         wr_valid_i,
    input  logic [ADDR_W-1:0]            wr_addr_i,
    input  logic [DATA_W/8-1:0]          wr_strb_i,
    input  logic [DATA_W-1:0]            wr_data_i,
    output logic                         wr_ready_o,
    output logic                         ram_en_o,
    output logic [DATA_W/8-1:0]          ram_we_o,
    output logic [ADDR_W-1:0]            ram_addr_o,
    output logic [DATA_W-1:0]            ram_data_o
);

    localparam int STRB_W = DATA_W / 8;
    localparam int LINE_W = ADDR_W - LINE_OFF_W;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FILL,
        ST_DONE
    } state_t;

    state_t                state_q,     state_d;
    logic [LINE_OFF_W-1:0] cnt_q,       cnt_d;
    logic [LINE_W-1:0]     line_q,      line_d;
    logic                  fill_done_q, fill_done_d;
    logic                  ram_en_q,    ram_en_d;
    logic [STRB_W-1:0]     ram_we_q,    ram_we_d;
    logic [ADDR_W-1:0]     ram_addr_q,  ram_addr_d;
    logic [DATA_W-1:0]     ram_data_q,  ram_data_d;

    // Handshake outputs are forced low while reset is asserted, independent of fill_req_i.
    assign fill_busy_o = arst_n_i && (state_q != ST_IDLE);
    assign be_ready_o  = arst_n_i && (state_q == ST_FILL);
    assign wr_ready_o  = arst_n_i && (state_q == ST_IDLE) && !fill_req_i;

    always_comb begin
        // NOTE: every _d gets a default before the case so no path leaves it unassigned (no latch).
        state_d     = state_q;
        cnt_d       = cnt_q;
        line_d      = line_q;
        fill_done_d = 1'b0;
        ram_en_d    = 1'b0;
        ram_we_d    = '0;
        ram_addr_d  = ram_addr_q;
        ram_data_d  = ram_data_q;

        unique case (state_q)
            ST_IDLE: begin
                if (fill_req_i) begin
                    state_d = ST_FILL;
                    line_d  = fill_line_i;
                    cnt_d   = '0;
                end else if (wr_valid_i) begin
                    ram_en_d   = 1'b1;
                    ram_we_d   = wr_strb_i;
                    ram_addr_d = wr_addr_i;
                    ram_data_d = wr_data_i;
                end
            end
            ST_FILL: begin
                if (be_valid_i) begin
                    ram_en_d   = 1'b1;
                    ram_we_d   = '1;
                    ram_addr_d = {line_q, cnt_q};
                    ram_data_d = be_data_i;
                    cnt_d      = cnt_q + 1'b1;
                    // Last word: done pulse lands in DONE, together with this word's RAM write.
                    if (cnt_q == {LINE_OFF_W{1'b1}}) begin
                        state_d     = ST_DONE;
                        fill_done_d = 1'b1;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            line_q      <= '0;
            fill_done_q <= 1'b0;
            ram_en_q    <= 1'b0;
            ram_we_q    <= '0;
            ram_addr_q  <= '0;
            ram_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            line_q      <= line_d;
            fill_done_q <= fill_done_d;
            ram_en_q    <= ram_en_d;
            ram_we_q    <= ram_we_d;
            ram_addr_q  <= ram_addr_d;
            ram_data_q  <= ram_data_d;
        end
    end

    assign fill_done_o = fill_done_q;
    assign ram_en_o    = ram_en_q;
    assign ram_we_o    = ram_we_q;
    assign ram_addr_o  = ram_addr_q;
    assign ram_data_o  = ram_data_q;

endmodule
